// File: rtl/sub98_pkg.sv
// rtl/sub98_pkg.sv - shared types and constants for the bit-serial inverse adder
// Purpose : FSM state encoding and default operand width for sub98_serial.
// Ports   : none (package).
package sub98_pkg;

    // Default width of y and x; z is one bit wider.
    localparam int SUB98_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub98_serial_full_subtractor.sv
// rtl/sub98_serial_full_subtractor.sv - one-bit full subtractor cell
// Purpose : d = a - b - bin for single bits, with borrow out.
// Ports   : a, b, bin (in, 1 bit each); d, bout (out, 1 bit each).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a is 0 and b is 1, or when a equals b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub98_serial.sv
// rtl/sub98_serial.sv - bit-serial recovery of x = z - y, one bit per clock
// Purpose : Undoes a W+W->W+1 ripple add. start/busy/done handshake; W+1 RUN cycles.
// Ports   : clk, rst_n (async active-low), start, z[W:0], y[W-1:0],
//           abort (only when SUB98_ABORT_EN is defined),
//           busy, done (one-cycle pulse), x[W-1:0], borrow, ovf.
// Config  : SUB98_ABORT_EN adds the abort input; abort in RUN returns to IDLE
//           without a done pulse and leaves x/borrow/ovf untouched.
module sub98_serial
    import sub98_pkg::*;
#(
    parameter int W = SUB98_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W:0]   z,
    input  logic [W-1:0] y,
`ifdef SUB98_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x,
    output logic         borrow,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     z_q, z_d;
    logic [W:0]     y_q, y_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           b_q, b_d;
    logic [W-1:0]   x_q, x_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;

    logic           d_bit;
    logic           b_out;
    logic           last_bit;
    logic           abort_run;

    // The current bit always sits at position 0 of the operand shift registers.
    full_subtractor u_fs (
        .a    (z_q[0]),
        .b    (y_q[0]),
        .bin  (b_q),
        .d    (d_bit),
        .bout (b_out)
    );

    assign last_bit = (cnt_q == CW'(W));

`ifdef SUB98_ABORT_EN
    assign abort_run = abort && (state_q == RUN);
`else
    assign abort_run = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        y_d      = y_q;
        diff_d   = diff_q;
        b_d      = b_q;
        x_d      = x_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    z_d     = z;
                    y_d     = {1'b0, y};
                    cnt_d   = '0;
                    b_d     = 1'b0;
                end
            end
            RUN: begin
                if (abort_run) begin
                    state_d = IDLE;
                end else begin
                    z_d   = z_q >> 1;
                    y_d   = y_q >> 1;
                    b_d   = b_out;
                    cnt_d = cnt_q + CW'(1);
                    if (last_bit) begin
                        // Bit W is the overflow bit; bits 0..W-1 are already in diff_q.
                        state_d  = DONE;
                        x_d      = diff_q;
                        borrow_d = b_out;
                        ovf_d    = d_bit & ~b_out;
                    end else begin
                        diff_d = {d_bit, diff_q[W-1:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            z_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            b_q      <= 1'b0;
            x_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            y_q      <= y_d;
            diff_q   <= diff_d;
            b_q      <= b_d;
            x_q      <= x_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign x      = x_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule
